// File: rtl/queue_if.sv
// Handshake and data bundle between a queue and its producer/consumer.
// The slave side is the queue itself.
interface queue_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] dat_i;
   logic                 push_i;
   logic                 pop_i;
   logic [DATA_BITS-1:0] dat_o;
   logic                 full_o;
   logic                 empty_o;

   modport slave (
      input  dat_i,
      input  push_i,
      input  pop_i,
      output dat_o,
      output full_o,
      output empty_o
   );

   modport master (
      output dat_i,
      output push_i,
      output pop_i,
      input  dat_o,
      input  full_o,
      input  empty_o
   );
endinterface

// File: rtl/queue.sv
// Single-clock circular-buffer FIFO with show-ahead read data.
// The free-slot count is the only occupancy state; both flags are decoded from it.
module queue #(
   parameter int DEPTH_BITS = 3,
   parameter int DATA_BITS  = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   queue_if.slave                q_if,
   output logic [DEPTH_BITS-1:0] rp_to,
   output logic [DEPTH_BITS-1:0] wp_to,
   output logic [DEPTH_BITS:0]   room_to,
   output logic                  we_to
);
   localparam int                  ENTRIES   = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] ROOM_MAX  = {1'b1, {DEPTH_BITS{1'b0}}};
   localparam logic [DEPTH_BITS:0] ROOM_ZERO = {(DEPTH_BITS+1){1'b0}};
   localparam logic [DEPTH_BITS:0] ROOM_ONE  = (DEPTH_BITS+1)'(1);
   localparam logic [DEPTH_BITS-1:0] PTR_ZERO = {DEPTH_BITS{1'b0}};
   localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

   logic [DATA_BITS-1:0]  mem_q [ENTRIES];
   logic [DEPTH_BITS-1:0] rp_q;
   logic [DEPTH_BITS-1:0] rp_d;
   logic [DEPTH_BITS-1:0] wp_q;
   logic [DEPTH_BITS-1:0] wp_d;
   logic [DEPTH_BITS:0]   room_q;
   logic [DEPTH_BITS:0]   room_d;
   logic                  full_s;
   logic                  empty_s;
   logic                  we_s;
   logic                  re_s;

   assign full_s  = (room_q == ROOM_ZERO);
   assign empty_s = (room_q == ROOM_MAX);
   // Reset blocks acceptance so the storage is never written in a reset cycle.
   assign we_s    = q_if.push_i & ~full_s  & ~reset_i;
   assign re_s    = q_if.pop_i  & ~empty_s & ~reset_i;

   // Next-state pointers and free-slot count.
   always_comb begin
      rp_d   = rp_q;
      wp_d   = wp_q;
      room_d = room_q;
      if (we_s) begin
         wp_d = wp_q + PTR_ONE;
      end else begin
         wp_d = wp_q;
      end
      if (re_s) begin
         rp_d = rp_q + PTR_ONE;
      end else begin
         rp_d = rp_q;
      end
      case ({we_s, re_s})
         2'b10:   room_d = room_q - ROOM_ONE;
         2'b01:   room_d = room_q + ROOM_ONE;
         default: room_d = room_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rp_q   <= PTR_ZERO;
         wp_q   <= PTR_ZERO;
         room_q <= ROOM_MAX;
      end else begin
         rp_q   <= rp_d;
         wp_q   <= wp_d;
         room_q <= room_d;
      end
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (we_s) begin
         mem_q[wp_q] <= q_if.dat_i;
      end
   end

   assign q_if.dat_o   = mem_q[rp_q];
   assign q_if.full_o  = full_s;
   assign q_if.empty_o = empty_s;
   assign rp_to        = rp_q;
   assign wp_to        = wp_q;
   assign room_to      = room_q;
   assign we_to        = we_s;
endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue: directed test-plan phases plus random traffic,
// all checked against a reference model built on an SV queue.
module tb_queue;
   logic       clk_i;
   logic       reset_i;
   logic [2:0] rp_to;
   logic [2:0] wp_to;
   logic [3:0] room_to;
   logic       we_to;

   int errors;
   int checks;

   // Reference state: the stored words in order, plus count of accepted ops since reset.
   logic [7:0] model_q[$];
   int         m_pushes;
   int         m_pops;

   queue_if #(.DATA_BITS(8)) qif ();

   queue #(.DEPTH_BITS(3), .DATA_BITS(8)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .q_if    (qif),
      .rp_to   (rp_to),
      .wp_to   (wp_to),
      .room_to (room_to),
      .we_to   (we_to)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive, check the pre-edge view against the model, advance the model, clock.
   task automatic cycle(input logic psh, input logic pp, input logic [7:0] d, input logic rst);
      bit exp_we;
      bit exp_re;
      int sz;
      qif.push_i = psh;
      qif.pop_i  = pp;
      qif.dat_i  = d;
      reset_i    = rst;
      #1;
      sz = model_q.size();
      exp_we = psh && !rst && (sz < 8);
      exp_re = pp && !rst && (sz > 0);
      check_eq("rp_to",   32'(rp_to),   32'(m_pops % 8));
      check_eq("wp_to",   32'(wp_to),   32'(m_pushes % 8));
      check_eq("room_to", 32'(room_to), 32'(8 - sz));
      check_eq("full_o",  32'(qif.full_o),  32'(sz == 8));
      check_eq("empty_o", 32'(qif.empty_o), 32'(sz == 0));
      check_eq("we_to",   32'(we_to),   32'(exp_we));
      if (sz != 0) begin
         check_eq("dat_o", 32'(qif.dat_o), 32'(model_q[0]));
      end
      if (rst) begin
         model_q.delete();
         m_pushes = 0;
         m_pops   = 0;
      end else begin
         if (exp_re) begin
            void'(model_q.pop_front());
            m_pops = m_pops + 1;
         end
         if (exp_we) begin
            model_q.push_back(d);
            m_pushes = m_pushes + 1;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      m_pushes = 0;
      m_pops   = 0;
      qif.push_i = 1'b0;
      qif.pop_i  = 1'b0;
      qif.dat_i  = 8'h00;
      reset_i    = 1'b1;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      // Reset state, then fill past full with 0xFF.
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'hFF, 1'b0);
      check_eq("fill_full", 32'(qif.full_o), 32'd1);
      check_eq("fill_wp_wrap", 32'(wp_to), 32'd0);

      // Drain past empty.
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check_eq("drain_empty", 32'(qif.empty_o), 32'd1);
      check_eq("drain_room", 32'(room_to), 32'd8);

      // Ordering 01..08.
      for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

      // Concurrent push/pop with 3 queued.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
         check_eq("conc_room", 32'(room_to), 32'd5);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

      // Mid-operation reset with push asserted.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
      cycle(1'b1, 1'b0, 8'hAA, 1'b1);
      check_eq("rst_room", 32'(room_to), 32'd8);
      check_eq("rst_empty", 32'(qif.empty_o), 32'd1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);

      // Random traffic with phase-varying push/pop bias and rare resets.
      for (int i = 0; i < 600; i++) begin
         int bias;
         bias = ((i / 100) % 2 == 0) ? 70 : 30;
         cycle(($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < (100 - bias)) ? 1'b1 : 1'b0,
               8'($urandom),
               ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/queue.md
Name: queue

Overview:
- Synchronous, single-clock circular-buffer FIFO with parameterised depth (2^DEPTH_BITS entries) and data width.
- Producers push words; consumers pop them in first-in, first-out order.
- Full and empty flags provide flow control.
- Read pointer, write pointer, free-slot count and write-enable are exported as test outputs for bench observability.

Parameters:
- DEPTH_BITS, 3, log2 of entry count (default 8 entries).
- DATA_BITS, 8, width of each stored word.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- dat_i  input  DATA_BITS  data to enqueue.
- push_i  input  1  enqueue request.
- pop_i  input  1  dequeue request.
- dat_o  output  DATA_BITS  head-of-queue word.
- full_o  output  1  queue holds 2^DEPTH_BITS words.
- empty_o  output  1  queue holds 0 words.
- rp_to  output  DEPTH_BITS  read pointer (test output).
- wp_to  output  DEPTH_BITS  write pointer (test output).
- room_to  output  DEPTH_BITS+1  free-slot count, 0..2^DEPTH_BITS (test output).
- we_to  output  1  push accepted this cycle (test output).

Behaviour:
- Reset (reset_i=1 at rising edge): rp=0, wp=0, room=2^DEPTH_BITS.
  - Resulting flags: empty_o=1, full_o=0.
  - Reset overrides push/pop in the same cycle.
  - Storage contents are not cleared.
- Reset mid-operation discards all queued data; the queue is empty from the next cycle.
- Flags are combinational from room:
  - full_o = (room==0).
  - empty_o = (room==2^DEPTH_BITS).
- Push accept: we_to = push_i & ~full_o & ~reset_i (combinational).
  - On accept: mem[wp] <= dat_i; wp <= wp+1 (wraps modulo 2^DEPTH_BITS).
- Pop accept: pop_i & ~empty_o & ~reset_i.
  - On accept: rp <= rp+1 (wraps modulo 2^DEPTH_BITS).
- Room update per cycle:
  - push only: room-1.
  - pop only: room+1.
  - both or neither: unchanged.
- Push while full: ignored; wp and room unchanged, no overwrite. Applies even if pop_i is also asserted; the pop still proceeds.
- Pop while empty: ignored; rp and room unchanged. Applies even if push_i is also asserted; the push still proceeds.
- Simultaneous push and pop when neither full nor empty: both accepted; wp and rp each advance; room unchanged.
- dat_o = mem[rp], combinational (show-ahead).
  - Valid whenever empty_o=0; value undefined when empty.
  - The word at dat_o is consumed at the rising edge where a pop is accepted.
  - A word pushed at edge N is visible on dat_o after edge N if the queue was empty.
- Pointer values wrap; after 2^DEPTH_BITS accepted pushes from reset, wp_to returns to 0.
- Read and write may address the same entry only when the queue is empty or full; no bypass path is required.

Test Plan:
- Reset: hold reset_i one cycle -> rp_to=0, wp_to=0, room_to=8, empty_o=1, full_o=0.
- Fill: push_i=1 for 9 cycles with dat_i=8'hFF.
  - After cycles 1..7: wp_to=1..7, room_to=7..1, rp_to=0.
  - After cycle 8: wp_to=0, room_to=0, full_o=1.
  - 9th push ignored (room_to=0, wp_to=0, we_to=0).
- Drain: pop_i=1 for 9 cycles.
  - rp_to steps 1..7 then 0; room_to 1..8.
  - After cycle 8: empty_o=1.
  - 9th pop ignored (rp_to=0, room_to=8).
- Ordering: push 8'h01..8'h08, then pop 8 times -> dat_o reads 01,02,...,08 in order before each pop edge.
- Concurrent: with 3 entries queued, assert push_i and pop_i together for 10 cycles -> room_to stays 5, both pointers advance and wrap, dat_o sequence preserves FIFO order.
- Mid-operation reset: with 5 entries queued, assert reset_i together with push_i -> next cycle rp_to=0, wp_to=0, room_to=8, empty_o=1.
